// File: rtl/count2_a_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | count2_a_decoder: link monitor that recovers x from a count2_a       |
// | stream and flags illegal transitions once locked.  Rev 1.0           |
// +----------------------------------------------------------------------+
module count2_a_decoder #(
    parameter int RESYNC_LEN = 2,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    input  logic [1:0]           count_in_i,
    output logic                 x_rec_o,
    output logic                 x_rec_valid_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_count_o,
    output logic                 locked_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACQ  = 2'd1,
        S_LOCK = 2'd2
    } state_t;

    localparam logic [3:0]           RUN_TARGET = 4'(RESYNC_LEN);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

    state_t               state_q, state_d;
    logic [1:0]           prev_q, prev_d;
    logic [3:0]           run_q, run_d;
    logic                 x_rec_q, x_rec_d;
    logic                 x_rec_valid_q, x_rec_valid_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    logic w_legal;
    logic w_decision;
    logic w_x;

    always_comb begin
        w_legal    = 1'b0;
        w_decision = 1'b0;
        w_x        = 1'b0;
        case ({prev_q, count_in_i})
            4'b00_01: begin w_legal = 1'b1; w_decision = 1'b1; w_x = 1'b0; end
            4'b00_10: begin w_legal = 1'b1; w_decision = 1'b1; w_x = 1'b1; end
            4'b01_10: begin w_legal = 1'b1; w_decision = 1'b1; w_x = 1'b0; end
            4'b01_01: begin w_legal = 1'b1; w_decision = 1'b1; w_x = 1'b1; end
            4'b10_11: w_legal = 1'b1;
            4'b11_00: w_legal = 1'b1;
            default:  w_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        run_d         = run_q;
        x_rec_d       = x_rec_q;
        x_rec_valid_d = 1'b0;
        err_d         = 1'b0;
        err_count_d   = err_count_q;
        if (in_valid_i) begin
            prev_d = count_in_i;
            case (state_q)
                S_IDLE: begin
                    state_d = S_ACQ;
                    run_d   = 4'd0;
                end
                S_ACQ: begin
                    if (w_legal) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == RUN_TARGET) state_d = S_LOCK;
                    end else begin
                        run_d = 4'd0;
                    end
                end
                S_LOCK: begin
                    if (w_legal) begin
                        if (w_decision) begin
                            x_rec_valid_d = 1'b1;
                            x_rec_d       = w_x;
                        end
                    end else begin
                        // The offending sample becomes the new reference via prev_d.
                        err_d   = 1'b1;
                        state_d = S_ACQ;
                        run_d   = 4'd0;
                        if (err_count_q != ERR_MAX) err_count_d = err_count_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    run_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            prev_q        <= 2'b00;
            run_q         <= 4'd0;
            x_rec_q       <= 1'b0;
            x_rec_valid_q <= 1'b0;
            err_q         <= 1'b0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            run_q         <= run_d;
            x_rec_q       <= x_rec_d;
            x_rec_valid_q <= x_rec_valid_d;
            err_q         <= err_d;
            err_count_q   <= err_count_d;
        end
    end

    assign x_rec_o       = x_rec_q;
    assign x_rec_valid_o = x_rec_valid_q;
    assign err_o         = err_q;
    assign err_count_o   = err_count_q;
    assign locked_o      = (state_q == S_LOCK);

endmodule
`default_nettype wire

// File: tb/tb_count2_a_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_count2_a_decoder: directed scoreboard bench for count2_a_decoder. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_count2_a_decoder;

    localparam int RESYNC_LEN = 2;
    localparam int ERR_CNT_W  = 2;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 in_valid = 1'b0;
    logic [1:0]           count_in = 2'b00;
    logic                 x_rec;
    logic                 x_rec_valid;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 locked;

    typedef struct {
        logic                 xr;
        logic                 xv;
        logic                 er;
        logic [ERR_CNT_W-1:0] ec;
        logic                 lk;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   step_no = 0;

    count2_a_decoder #(
        .RESYNC_LEN(RESYNC_LEN),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid),
        .count_in_i   (count_in),
        .x_rec_o      (x_rec),
        .x_rec_valid_o(x_rec_valid),
        .err_o        (err),
        .err_count_o  (err_count),
        .locked_o     (locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s step=%0d observed=%b expected=%b", tag, step_no, obs, exp);
        end
    endtask

    task automatic check_front();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard step=%0d observed=empty expected=entry", step_no);
            return;
        end
        e = sb.pop_front();
        cmp("x_rec",       {1'b0, x_rec},       {1'b0, e.xr});
        cmp("x_rec_valid", {1'b0, x_rec_valid}, {1'b0, e.xv});
        cmp("err",         {1'b0, err},         {1'b0, e.er});
        cmp("err_count",   err_count,           e.ec);
        cmp("locked",      {1'b0, locked},      {1'b0, e.lk});
    endtask

    // Drive one cycle, queue the expected registered response, compare after the edge.
    task automatic step(input logic rst, input logic v, input logic [1:0] c,
                        input logic xr, input logic xv, input logic er,
                        input logic [ERR_CNT_W-1:0] ec, input logic lk);
        exp_t e;
        @(negedge clk);
        rst_ni   = rst;
        in_valid = v;
        count_in = c;
        e.xr = xr; e.xv = xv; e.er = er; e.ec = ec; e.lk = lk;
        sb.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        check_front();
    endtask

    initial begin
        exp_t e;
        logic [ERR_CNT_W-1:0] ec_exp;

        // T1: reset held with random stimulus
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0, 0, 0, 2'd0, 0);

        // T2: acquire
        step(1, 1, 2'b00, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b01, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b10, 0, 0, 0, 2'd0, 1);

        // T3: decode from prev=11
        step(1, 1, 2'b11, 0, 0, 0, 2'd0, 1);
        step(1, 1, 2'b00, 0, 0, 0, 2'd0, 1);
        step(1, 1, 2'b01, 0, 1, 0, 2'd0, 1);
        step(1, 1, 2'b01, 1, 1, 0, 2'd0, 1);
        step(1, 1, 2'b10, 0, 1, 0, 2'd0, 1);
        step(1, 1, 2'b11, 0, 0, 0, 2'd0, 1);
        step(1, 1, 2'b00, 0, 0, 0, 2'd0, 1);
        step(1, 1, 2'b10, 1, 1, 0, 2'd0, 1);

        // T4: illegal 10->00 while locked, then relock
        step(1, 1, 2'b00, 1, 0, 1, 2'd1, 0);
        step(1, 1, 2'b01, 1, 0, 0, 2'd1, 0);
        step(1, 1, 2'b10, 1, 0, 0, 2'd1, 1);

        // Synchronous-to-bench reset pulse clears err_count and x_rec
        step(0, 0, 2'b00, 0, 0, 0, 2'd0, 0);

        // ACQ illegal transition restarts the run without err
        step(1, 1, 2'b00, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b01, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b00, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b01, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b10, 0, 0, 0, 2'd0, 1);

        // T5: saturation with ERR_CNT_W=2
        ec_exp = 2'd0;
        for (int k = 1; k <= 5; k++) begin
            if (k <= 3) ec_exp = 2'(k);
            step(1, 1, 2'b00, 0, 0, 1, ec_exp, 0);
            step(1, 1, 2'b01, 0, 0, 0, ec_exp, 0);
            step(1, 1, 2'b10, 0, 0, 0, ec_exp, 1);
        end

        // T6: gaps while locked
        step(1, 1, 2'b11, 0, 0, 0, 2'd3, 1);
        for (int g = 0; g < 3; g++)
            step(1, 0, 2'(g), 0, 0, 0, 2'd3, 1);
        step(1, 1, 2'b00, 0, 0, 0, 2'd3, 1);
        step(1, 1, 2'b01, 0, 1, 0, 2'd3, 1);
        step(1, 0, 2'b11, 0, 0, 0, 2'd3, 1);
        step(1, 1, 2'b01, 1, 1, 0, 2'd3, 1);
        step(1, 0, 2'b00, 1, 0, 0, 2'd3, 1);

        // Asynchronous reset mid-run, checked before any clock edge
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        e.xr = 0; e.xv = 0; e.er = 0; e.ec = 2'd0; e.lk = 0;
        sb.push_back(e);
        step_no++;
        check_front();

        // After release the first sample lands in IDLE with no pulses
        step(1, 1, 2'b01, 0, 0, 0, 2'd0, 0);
        step(1, 1, 2'b01, 0, 0, 0, 2'd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
